// File: rtl/puzzle_pkg.sv
// puzzle_pkg: shared types, the solved-board constant and neighbour/legality
// helpers for the 4x4 sliding-puzzle board.
package puzzle_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        SCRAMBLE,
        PLAY,
        DONE
    } board_state_t;

    typedef logic [15:0][3:0] board_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] idx;
    } nbr_t;

    localparam board_t SOLVED_BOARD = {
        4'd0,  4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9,
        4'd8,  4'd7,  4'd6,  4'd5,  4'd4,  4'd3,  4'd2,  4'd1
    };

    // Direction is the tile's motion, so the tile that slides in sits opposite it.
    function automatic nbr_t neighbour(input logic [3:0] blank, input dir_t dir);
        nbr_t n;
        n.legal = 1'b0;
        n.idx   = blank;
        case (dir)
            UP:      begin n.legal = (blank[3:2] != 2'd3); n.idx = blank + 4'd4; end
            DOWN:    begin n.legal = (blank[3:2] != 2'd0); n.idx = blank - 4'd4; end
            LEFT:    begin n.legal = (blank[1:0] != 2'd3); n.idx = blank + 4'd1; end
            default: begin n.legal = (blank[1:0] != 2'd0); n.idx = blank - 4'd1; end
        endcase
        return n;
    endfunction

    function automatic dir_t inverse(input dir_t dir);
        return dir_t'(dir ^ 2'b01);
    endfunction

endpackage

// File: rtl/puzzle_board_if.sv
// puzzle_board_if: start/move/read bus between the game side and puzzle_board.
// With BOARD_UNDO_EN defined the bus also carries the undo request.
interface puzzle_board_if;
    logic [2:0] start;
    logic       in_game;
    logic       move_valid;
    logic [1:0] move_dir;
    logic [3:0] rd_idx;
    logic [3:0] rd_tile;
    logic [3:0] blank_pos;
    logic [7:0] move_count;
    logic       busy;
    logic       win;
    logic       lose;
`ifdef BOARD_UNDO_EN
    logic       undo;

    modport master (
        output start, in_game, move_valid, move_dir, rd_idx, undo,
        input  rd_tile, blank_pos, move_count, busy, win, lose
    );
    modport slave (
        input  start, in_game, move_valid, move_dir, rd_idx, undo,
        output rd_tile, blank_pos, move_count, busy, win, lose
    );
`else
    modport master (
        output start, in_game, move_valid, move_dir, rd_idx,
        input  rd_tile, blank_pos, move_count, busy, win, lose
    );
    modport slave (
        input  start, in_game, move_valid, move_dir, rd_idx,
        output rd_tile, blank_pos, move_count, busy, win, lose
    );
`endif
endinterface

// File: rtl/puzzle_lfsr16.sv
// puzzle_lfsr16: 16-bit Fibonacci LFSR (taps 16,14,13,11) with enable and
// seed load; shared by the randomised blocks.
module puzzle_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        en,
    output logic [15:0] value
);
    logic feedback;

    assign feedback = value[0] ^ value[2] ^ value[3] ^ value[5];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            value <= SEED;
        end else if (load) begin
            value <= seed;
        end else if (en) begin
            value <= {feedback, value[15:1]};
        end
    end
endmodule

// File: rtl/puzzle_board.sv
// puzzle_board: 4x4 sliding-puzzle tile array with LFSR scramble, player moves
// and sticky win/lose flags. BOARD_UNDO_EN adds a one-deep undo of the last move.
module puzzle_board
    import puzzle_pkg::*;
#(
    parameter int          EZ_MOVES     = 10,
    parameter int          NORMAL_MOVES = 40,
    parameter int          HARD_MOVES   = 120,
    parameter int          MOVE_LIMIT   = 200,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input logic           clk,
    input logic           resetn,
    puzzle_board_if.slave bus
);
    board_t       board;
    board_state_t state;
    logic [3:0]   blank;
    logic [7:0]   remaining;
    logic [7:0]   move_count;
    logic         prev_valid;
    dir_t         prev_dir;
    logic         check_pending;
    logic         busy;
    logic         win;
    logic         lose;
    logic [15:0]  lfsr;
    logic         start_hit;
    logic [7:0]   start_moves;
    dir_t         scr_dir;
    dir_t         play_dir;
    nbr_t         scr_nbr;
    nbr_t         play_nbr;
    logic         scr_ok;
    logic         move_ok;
    logic         solved;
    logic         lfsr_en;
`ifdef BOARD_UNDO_EN
    logic         last_valid;
    dir_t         last_dir;
    nbr_t         undo_nbr;
    logic         undo_ok;
`endif

    always_comb begin
        start_hit   = 1'b1;
        start_moves = 8'd0;
        case (bus.start)
            3'b001:  start_moves = 8'(EZ_MOVES);
            3'b010:  start_moves = 8'(NORMAL_MOVES);
            3'b100:  start_moves = 8'(HARD_MOVES);
            default: start_hit   = 1'b0;
        endcase
    end

    // Scramble never undoes its own previous step, so the walk does not stall.
    assign scr_dir  = dir_t'(lfsr[1:0]);
    assign scr_nbr  = neighbour(blank, scr_dir);
    assign scr_ok   = scr_nbr.legal && !(prev_valid && (scr_dir == inverse(prev_dir)));
    assign play_dir = dir_t'(bus.move_dir);
    assign play_nbr = neighbour(blank, play_dir);
    assign move_ok  = bus.move_valid && bus.in_game && play_nbr.legal;
    assign solved   = (board == SOLVED_BOARD);
    assign lfsr_en  = (state == SCRAMBLE) && !start_hit && (remaining != 8'd0);
`ifdef BOARD_UNDO_EN
    assign undo_nbr = neighbour(blank, inverse(last_dir));
    assign undo_ok  = bus.undo && !bus.move_valid && last_valid;
`endif

    puzzle_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .load   (1'b0),
        .seed   (LFSR_SEED),
        .en     (lfsr_en),
        .value  (lfsr)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            board         <= SOLVED_BOARD;
            blank         <= 4'd15;
            state         <= IDLE;
            remaining     <= 8'd0;
            move_count    <= 8'd0;
            prev_valid    <= 1'b0;
            prev_dir      <= UP;
            check_pending <= 1'b0;
            busy          <= 1'b0;
            win           <= 1'b0;
            lose          <= 1'b0;
`ifdef BOARD_UNDO_EN
            last_valid    <= 1'b0;
            last_dir      <= UP;
`endif
        end else if (start_hit) begin
            board         <= SOLVED_BOARD;
            blank         <= 4'd15;
            state         <= SCRAMBLE;
            remaining     <= start_moves;
            move_count    <= 8'd0;
            prev_valid    <= 1'b0;
            check_pending <= 1'b0;
            busy          <= 1'b1;
            win           <= 1'b0;
            lose          <= 1'b0;
`ifdef BOARD_UNDO_EN
            last_valid    <= 1'b0;
`endif
        end else begin
            case (state)
                SCRAMBLE: begin
                    if (remaining == 8'd0) begin
                        busy  <= 1'b0;
                        state <= PLAY;
                    end else if (scr_ok) begin
                        board[blank]       <= board[scr_nbr.idx];
                        board[scr_nbr.idx] <= 4'd0;
                        blank              <= scr_nbr.idx;
                        remaining          <= remaining - 8'd1;
                        prev_valid         <= 1'b1;
                        prev_dir           <= scr_dir;
                    end
                end
                // A pending end-of-game check takes the cycle; a coincident move is dropped.
                PLAY: begin
                    if (check_pending && solved) begin
                        win           <= 1'b1;
                        state         <= DONE;
                        check_pending <= 1'b0;
                    end else if (check_pending && (move_count == 8'(MOVE_LIMIT))) begin
                        lose          <= 1'b1;
                        state         <= DONE;
                        check_pending <= 1'b0;
                    end else if (move_ok) begin
                        board[blank]        <= board[play_nbr.idx];
                        board[play_nbr.idx] <= 4'd0;
                        blank               <= play_nbr.idx;
                        move_count          <= (move_count == 8'hFF) ? move_count : move_count + 8'd1;
                        check_pending       <= 1'b1;
`ifdef BOARD_UNDO_EN
                        last_valid          <= 1'b1;
                        last_dir            <= play_dir;
                    end else if (undo_ok) begin
                        board[blank]        <= board[undo_nbr.idx];
                        board[undo_nbr.idx] <= 4'd0;
                        blank               <= undo_nbr.idx;
                        move_count          <= (move_count == 8'd0) ? move_count : move_count - 8'd1;
                        check_pending       <= 1'b1;
                        last_valid          <= 1'b0;
`endif
                    end else begin
                        check_pending <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.rd_tile    = board[bus.rd_idx];
    assign bus.blank_pos  = blank;
    assign bus.move_count = move_count;
    assign bus.busy       = busy;
    assign bus.win        = win;
    assign bus.lose       = lose;
endmodule
